// File: rtl/apb_regs_pkg.sv
// Shared types and helpers for the multi-bank APB register completer.
package apb_regs_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

    localparam int WCNT_W  = 4;
    localparam int SEL_MAX = 64;

    // True when exactly one bit of the (zero-extended) select vector is set.
    function automatic logic onehot_chk(input logic [SEL_MAX-1:0] vec);
        return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
    endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// One register bank: DEPTH words with a byte-strobe write port and an async read port.
module apb_reg_bank
    import apb_regs_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     hresetn,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] widx,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [DATA_W/8-1:0]      wstrb,
    input  logic [$clog2(DEPTH)-1:0] ridx,
    output logic [DATA_W-1:0]        rdata
);

    localparam int STRB_W = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[widx][b*8 +: 8] <= wdata[b*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[ridx];

endmodule

// File: rtl/apb_multi_slave_regs.sv
// APB4 completer fronting NUM_SLV register banks, with strobes, wait states and pslverr.
// Wait-state insertion is enabled by defining APB_WAIT_STATES_EN.
module apb_multi_slave_regs
    import apb_regs_pkg::*;
#(
    parameter int NUM_SLV  = 4,
    parameter int DEPTH    = 16,
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 2
) (
    input  logic                  clk,
    input  logic                  hresetn,
    input  logic [NUM_SLV-1:0]    pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_W-1:0]     paddr,
    input  logic [DATA_W-1:0]     pwdata,
    input  logic [DATA_W/8-1:0]   pstrb,
    output logic [DATA_W-1:0]     prdata,
    output logic                  pready,
    output logic                  pslverr
);

    localparam int STRB_W = DATA_W / 8;
    localparam int BYTE_W = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam int BANK_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    apb_state_e        state;
    apb_state_e        stateNext;
    logic [BANK_W-1:0] selIdx;
    logic [BANK_W-1:0] bankQ;
    logic [IDX_W-1:0]  wordQ;
    logic              writeQ;
    logic              errQ;
    logic [WCNT_W-1:0] wcnt;
    logic              setupReq;
    logic              setupTake;
    logic              accessStart;
    logic              commit;
    logic              addrErr;
    logic [DATA_W-1:0] bankRdata [NUM_SLV];
    logic [NUM_SLV-1:0] bankWe;

    assign setupReq    = (|pselx) && !penable;
    assign setupTake   = setupReq && ((state == IDLE) || ((state == ACCESS) && pready));
    assign accessStart = (state == SETUP) && penable;
    assign commit      = pready && writeQ && !errQ;
    assign addrErr     = (paddr >> (BYTE_W + IDX_W)) != '0;

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (setupReq) stateNext = SETUP;
            SETUP:   stateNext = penable ? ACCESS : IDLE;
            ACCESS:  if (pready) stateNext = setupReq ? SETUP : IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_comb begin
        pready  = (state == ACCESS) && (wcnt == '0);
        pslverr = pready && errQ;
    end

    always_comb begin
        selIdx = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (pselx[i]) selIdx = i[BANK_W-1:0];
        end
    end

    // Transfer attributes are captured once per setup; ACCESS-phase bus changes are ignored.
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            bankQ  <= '0;
            wordQ  <= '0;
            writeQ <= 1'b0;
            errQ   <= 1'b0;
        end else if (setupTake) begin
            bankQ  <= selIdx;
            wordQ  <= paddr[BYTE_W +: IDX_W];
            writeQ <= pwrite;
            errQ   <= !onehot_chk(SEL_MAX'(pselx)) || addrErr;
        end
    end

`ifdef APB_WAIT_STATES_EN
    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            wcnt <= '0;
        end else if (accessStart) begin
            wcnt <= WCNT_W'(WAIT_CYC);
        end else if ((state == ACCESS) && (wcnt != '0)) begin
            wcnt <= wcnt - 1'b1;
        end
    end
`else
    assign wcnt = '0;
`endif

    always_ff @(posedge clk or negedge hresetn) begin
        if (!hresetn) begin
            prdata <= '0;
        end else if (accessStart && !writeQ && !errQ) begin
            prdata <= bankRdata[bankQ];
        end
    end

    for (genvar g = 0; g < NUM_SLV; g++) begin : gBank
        assign bankWe[g] = commit && (bankQ == BANK_W'(g));

        apb_reg_bank #(
            .DEPTH  (DEPTH),
            .DATA_W (DATA_W)
        ) uBank (
            .clk     (clk),
            .hresetn (hresetn),
            .we      (bankWe[g]),
            .widx    (wordQ),
            .wdata   (pwdata),
            .wstrb   (pstrb),
            .ridx    (wordQ),
            .rdata   (bankRdata[g])
        );
    end

endmodule

// File: tb/tb_apb_multi_slave_regs.sv
// Self-checking bench for apb_multi_slave_regs: directed table, corner sequences, random vs model.
module tb_apb_multi_slave_regs;

    localparam int NUM_SLV  = 4;
    localparam int DEPTH    = 16;
    localparam int ADDR_W   = 32;
    localparam int DATA_W   = 32;
    localparam int WAIT_CYC = 2;
`ifdef APB_WAIT_STATES_EN
    localparam int EXP_WAIT = WAIT_CYC;
`else
    localparam int EXP_WAIT = 0;
`endif
    localparam int MAX_WAIT = 40;

    logic              clk = 1'b0;
    logic              hresetn = 1'b0;
    logic [NUM_SLV-1:0] pselx = '0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic [DATA_W-1:0] pwdata = '0;
    logic [DATA_W/8-1:0] pstrb = '0;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    int compares = 0;
    int failures = 0;

    logic [DATA_W-1:0] modelMem [NUM_SLV][DEPTH];
    logic [DATA_W-1:0] modelPrdata;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        expErr;
        logic [31:0] expRd;
    } vec_t;

    vec_t vecs [16];

    apb_multi_slave_regs #(
        .NUM_SLV  (NUM_SLV),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .WAIT_CYC (WAIT_CYC)
    ) dut (
        .clk     (clk),
        .hresetn (hresetn),
        .pselx   (pselx),
        .penable (penable),
        .pwrite  (pwrite),
        .paddr   (paddr),
        .pwdata  (pwdata),
        .pstrb   (pstrb),
        .prdata  (prdata),
        .pready  (pready),
        .pslverr (pslverr)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compares++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic modelClear();
        for (int b = 0; b < NUM_SLV; b++)
            for (int w = 0; w < DEPTH; w++)
                modelMem[b][w] = '0;
        modelPrdata = '0;
    endtask

    // Reference behaviour: legal only for a single selected bank and an in-range word address.
    task automatic modelXfer(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                             input logic [31:0] wd, input logic [3:0] st,
                             output logic err, output logic [31:0] rd);
        int bank;
        int word;
        err = ($countones(sel) != 1) || (addr >= DEPTH * (DATA_W / 8));
        if (!err) begin
            bank = 0;
            for (int i = 0; i < NUM_SLV; i++) if (sel[i]) bank = i;
            word = (addr / (DATA_W / 8)) % DEPTH;
            if (wr) begin
                for (int b = 0; b < DATA_W / 8; b++)
                    if (st[b]) modelMem[bank][word][8*b +: 8] = wd[8*b +: 8];
            end else begin
                modelPrdata = modelMem[bank][word];
            end
        end
        rd = modelPrdata;
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input logic [31:0] addr, input logic wr,
                                 input logic [31:0] wd, input logic [3:0] st,
                                 output logic [31:0] rd, output logic err, output int waits);
        @(posedge clk); #1;
        pselx = sel; paddr = addr; pwrite = wr; pwdata = wd; pstrb = st; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        waits = 0;
        while (!pready && waits < MAX_WAIT) begin
            waits++;
            @(posedge clk); #1;
        end
        if (!pready) checkOutput("pready timeout", {31'b0, pready}, 32'h1);
        rd = prdata;
        err = pslverr;
        @(posedge clk); #1;
        pselx = '0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic runChecked(input string name, input logic [3:0] sel, input logic [31:0] addr,
                              input logic wr, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] rd;
        logic        err;
        int          waits;
        logic        expErr;
        logic [31:0] expRd;
        modelXfer(sel, addr, wr, wd, st, expErr, expRd);
        applyStimulus(sel, addr, wr, wd, st, rd, err, waits);
        checkOutput({name, " pslverr"}, {31'b0, err}, {31'b0, expErr});
        checkOutput({name, " prdata"}, rd, expRd);
        checkOutput({name, " waits"}, waits, EXP_WAIT);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        logic        dummyErr;
        logic [31:0] dummyRd;
        int          waits;
        logic [3:0]  rsel;
        logic [31:0] raddr;

        modelClear();

        vecs[0]  = '{4'b0010, 32'h008, 1'b1, 32'hDEADBEEF, 4'hF,    1'b0, 32'h00000000};
        vecs[1]  = '{4'b0010, 32'h008, 1'b0, 32'h00000000, 4'h0,    1'b0, 32'hDEADBEEF};
        vecs[2]  = '{4'b0001, 32'h000, 1'b1, 32'h11223344, 4'hF,    1'b0, 32'hDEADBEEF};
        vecs[3]  = '{4'b0001, 32'h000, 1'b1, 32'hAABBCCDD, 4'b0101, 1'b0, 32'hDEADBEEF};
        vecs[4]  = '{4'b0001, 32'h000, 1'b0, 32'h00000000, 4'h0,    1'b0, 32'h11BB33DD};
        vecs[5]  = '{4'b0011, 32'h008, 1'b1, 32'h00000000, 4'hF,    1'b1, 32'h11BB33DD};
        vecs[6]  = '{4'b0010, 32'h100, 1'b0, 32'h00000000, 4'h0,    1'b1, 32'h11BB33DD};
        vecs[7]  = '{4'b0010, 32'h008, 1'b0, 32'h00000000, 4'h0,    1'b0, 32'hDEADBEEF};
        vecs[8]  = '{4'b0001, 32'h008, 1'b0, 32'h00000000, 4'h0,    1'b0, 32'h00000000};
        vecs[9]  = '{4'b0100, 32'h00B, 1'b1, 32'h12345678, 4'hF,    1'b0, 32'h00000000};
        vecs[10] = '{4'b0100, 32'h008, 1'b0, 32'h00000000, 4'h0,    1'b0, 32'h12345678};
        vecs[11] = '{4'b0100, 32'h008, 1'b1, 32'hFFFFFFFF, 4'h0,    1'b0, 32'h12345678};
        vecs[12] = '{4'b0100, 32'h008, 1'b0, 32'h00000000, 4'h0,    1'b0, 32'h12345678};
        vecs[13] = '{4'b0100, 32'h048, 1'b0, 32'h00000000, 4'h0,    1'b1, 32'h12345678};
        vecs[14] = '{4'b1000, 32'h100, 1'b1, 32'hFFFFFFFF, 4'hF,    1'b1, 32'h12345678};
        vecs[15] = '{4'b1000, 32'h000, 1'b0, 32'h00000000, 4'h0,    1'b0, 32'h00000000};

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset prdata", prdata, 32'h0);
        checkOutput("reset pready", {31'b0, pready}, 32'h0);
        checkOutput("reset pslverr", {31'b0, pslverr}, 32'h0);
        hresetn = 1'b1;

        // Make prdata nonzero, then abort a write with reset in its ACCESS phase.
        runChecked("pre-reset write", 4'b0100, 32'h0, 1'b1, 32'h00000077, 4'hF);
        runChecked("pre-reset read", 4'b0100, 32'h0, 1'b0, 32'h0, 4'h0);
        @(posedge clk); #1;
        pselx = 4'b0010; paddr = 32'h30; pwrite = 1'b1; pwdata = 32'h55AA55AA; pstrb = 4'hF; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        #2 hresetn = 1'b0;
        #1;
        checkOutput("midreset prdata", prdata, 32'h0);
        checkOutput("midreset pready", {31'b0, pready}, 32'h0);
        checkOutput("midreset pslverr", {31'b0, pslverr}, 32'h0);
        pselx = '0; penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        hresetn = 1'b1;
        modelClear();
        runChecked("post-reset word", 4'b0010, 32'h30, 1'b0, 32'h0, 4'h0);
        runChecked("post-reset bank2", 4'b0100, 32'h0, 1'b0, 32'h0, 4'h0);

        for (int i = 0; i < 16; i++) begin
            modelXfer(vecs[i].sel, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, dummyErr, dummyRd);
            applyStimulus(vecs[i].sel, vecs[i].addr, vecs[i].wr, vecs[i].wdata, vecs[i].strb, rd, err, waits);
            checkOutput($sformatf("vec%0d pslverr", i), {31'b0, err}, {31'b0, vecs[i].expErr});
            checkOutput($sformatf("vec%0d prdata", i), rd, vecs[i].expRd);
            checkOutput($sformatf("vec%0d waits", i), waits, EXP_WAIT);
        end

        // Back-to-back: write bank3, then read it with the next setup overlapping the completion.
        @(posedge clk); #1;
        pselx = 4'b1000; paddr = 32'h14; pwrite = 1'b1; pwdata = 32'hCAFEF00D; pstrb = 4'hF; penable = 1'b0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        waits = 0;
        while (!pready && waits < MAX_WAIT) begin
            waits++;
            @(posedge clk); #1;
        end
        checkOutput("b2b write pready", {31'b0, pready}, 32'h1);
        checkOutput("b2b write waits", waits, EXP_WAIT);
        penable = 1'b0; pwrite = 1'b0;
        @(posedge clk); #1;
        checkOutput("b2b setup pready", {31'b0, pready}, 32'h0);
        penable = 1'b1;
        @(posedge clk); #1;
        waits = 0;
        while (!pready && waits < MAX_WAIT) begin
            waits++;
            @(posedge clk); #1;
        end
        checkOutput("b2b read pready", {31'b0, pready}, 32'h1);
        checkOutput("b2b read prdata", prdata, 32'hCAFEF00D);
        checkOutput("b2b read pslverr", {31'b0, pslverr}, 32'h0);
        @(posedge clk); #1;
        pselx = '0; penable = 1'b0;
        modelXfer(4'b1000, 32'h14, 1'b1, 32'hCAFEF00D, 4'hF, dummyErr, dummyRd);
        modelXfer(4'b1000, 32'h14, 1'b0, 32'h0, 4'h0, dummyErr, dummyRd);

        // Bank isolation on word 5.
        for (int k = 0; k < NUM_SLV; k++)
            runChecked($sformatf("iso init b%0d", k), 4'(1 << k), 32'h14, 1'b1, 32'h10000000 + k, 4'hF);
        for (int k = 0; k < NUM_SLV; k++) begin
            for (int j = 0; j < NUM_SLV; j++)
                runChecked($sformatf("iso step%0d rd b%0d", k, j), 4'(1 << j), 32'h14, 1'b0, 32'h0, 4'h0);
            runChecked($sformatf("iso step%0d wr", k), 4'(1 << k), 32'h14, 1'b1, 32'hA5A5A5A5, 4'hF);
        end
        for (int j = 0; j < NUM_SLV; j++)
            runChecked($sformatf("iso final b%0d", j), 4'(1 << j), 32'h14, 1'b0, 32'h0, 4'h0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) rsel = 4'($urandom_range(1, 15));
            else rsel = 4'(1 << $urandom_range(0, 3));
            raddr = ($urandom_range(0, DEPTH - 1) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 9) == 0) raddr = raddr | (32'h1 << $urandom_range(6, 31));
            runChecked($sformatf("rand%0d", n), rsel, raddr, 1'($urandom_range(0, 1)),
                       $urandom, 4'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", compares, failures);
        $finish;
    end

endmodule
